regfile_port_ctrl: RTL and testbench
====================================

// Module: regfile_port_ctrl
// PURPOSE
//  Two-requester controller for the single-write/dual-read register file (regfile).
//  Round-robin arbitration between requesters A and B, one transaction at a time.
//  Sequences the regfile en/rd/wt strobes and addresses, and returns read data with a done pulse.
//  Sits between the decode/execute and load units and the regfile.
// PARAMETERS
//  DW  32  data width; matches regfile ip/op1/op2
//  AW   4  register address width; matches regfile si/so1/so2
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  req_a      in   1   A requests a transaction; sampled only when the arbiter can grant
//  wr_a       in   1   1 = write wdata_a to waddr_a; 0 = read raddr1_a/raddr2_a
//  waddr_a    in   AW  write address
//  wdata_a    in   DW  write data
//  raddr1_a   in   AW  read address, port 1
//  raddr2_a   in   AW  read address, port 2
//  ack_a      out  1   one-cycle pulse: A's transaction is complete
//  rdata1_a   out  DW  read result 1; valid from the ack_a cycle; held until A's next read ack
//  rdata2_a   out  DW  read result 2; same rules as rdata1_a
//  (req_b, wr_b, waddr_b, wdata_b, raddr1_b, raddr2_b, ack_b, rdata1_b, rdata2_b: identical for B)
//  rf_en      out  1   regfile enable
//  rf_rd      out  1   regfile read strobe
//  rf_wt      out  1   regfile write strobe
//  rf_si      out  AW  regfile write select
//  rf_so1     out  AW  regfile read select 1
//  rf_so2     out  AW  regfile read select 2
//  rf_ip      out  DW  regfile write data
//  rf_op1     in   DW  regfile read data 1
//  rf_op2     in   DW  regfile read data 2
//  busy       out  1   high in ISSUE and DONE
// BEHAVIOUR
//  Regfile contract:
//   - Write on the rising edge where rf_en & rf_wt are high.
//   - rf_op1/rf_op2 are registered on the edge where rf_en & rf_rd are high; valid the next cycle.
//  FSM states: IDLE, ISSUE, DONE. Reset state is IDLE.
//  IDLE
//   - If req_a or req_b is high, grant one requester. Latch its wr, addresses and data into
//     internal registers, then go to ISSUE. Otherwise stay in IDLE.
//  ISSUE (exactly 1 cycle)
//   - Drive rf_en=1 and the latched addresses/data.
//   - Write: rf_wt=1, rf_rd=0. Read: rf_rd=1, rf_wt=0. rf_rd and rf_wt are never both high.
//   - Next state is DONE.
//  DONE (exactly 1 cycle)
//   - rf_en=rf_rd=rf_wt=0. Pulse ack of the granted requester.
//   - Read: register rf_op1/rf_op2 into that requester's rdata1/rdata2, visible in the ack cycle.
//   - Arbitrate exactly as in IDLE: if a request is pending go to ISSUE, else go to IDLE.
//  Timing:
//   - Latency from a granting edge to ack is 2 cycles.
//   - Back-to-back throughput is 1 transaction per 2 cycles.
//  Arbitration:
//   - Single requester: it wins.
//   - Both requesting: the one not granted last wins.
//   - last_grant resets to B, so A wins the first tie.
//  Request rules:
//   - Requester holds req high until its ack.
//   - req is re-sampled in the DONE cycle of its own transaction, so the requester must drop req
//     in the ack cycle unless it wants another transaction. Requests are not queued.
//   - Fields are latched at grant; changes after grant do not affect the transaction in flight.
//  Output values:
//   - rf_si/rf_so1/rf_so2/rf_ip hold their last values outside ISSUE.
//   - rdata of the non-granted requester never changes.
//  Reset (any time, including mid-transaction):
//   - Cleared to 0: all outputs, rdata registers and latched fields; last_grant set to B.
//   - FSM goes to IDLE; the in-flight transaction is dropped and no ack is issued.
//   - A write whose ISSUE edge coincides with reset is not guaranteed to land.
// TESTING
//  1. rst=1 for 2 cycles, then release -> all outputs 0, busy=0, no ack while req_a=req_b=0.
//  2. A writes 32'h11111111 to r0 -> rf_wt=1, rf_si=0 in ISSUE; ack_a 2 cycles after grant;
//     rf_rd never high.
//  3. After r0=32'h11111111 and r1=32'h22222222, A reads so1=0, so2=1 ->
//     rdata1_a=32'h11111111, rdata2_a=32'h22222222 at ack_a.
//  4. req_a and req_b rise together and are held -> grant order A,B,A,B; acks every 2 cycles;
//     ack_a/ack_b never both high.
//  5. B writes r3=32'hDEADBEEF, then A reads r3 -> rdata1_a=32'hDEADBEEF; rdata_b unchanged.
//  6. Assert rst during the ISSUE of a read -> no ack, FSM in IDLE, rdata=0;
//     after release the next request completes normally.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// Two-requester round-robin front end for the single-write/dual-read regfile.
// One transaction at a time: grant, one ISSUE cycle, one DONE cycle with ack and read data.
module regfile_port_ctrl #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          wr_a,
  input  logic [AW-1:0] waddr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic [AW-1:0] raddr1_a,
  input  logic [AW-1:0] raddr2_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata1_a,
  output logic [DW-1:0] rdata2_a,
  input  logic          req_b,
  input  logic          wr_b,
  input  logic [AW-1:0] waddr_b,
  input  logic [DW-1:0] wdata_b,
  input  logic [AW-1:0] raddr1_b,
  input  logic [AW-1:0] raddr2_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata1_b,
  output logic [DW-1:0] rdata2_b,
  output logic          rf_en,
  output logic          rf_rd,
  output logic          rf_wt,
  output logic [AW-1:0] rf_si,
  output logic [AW-1:0] rf_so1,
  output logic [AW-1:0] rf_so2,
  output logic [DW-1:0] rf_ip,
  input  logic [DW-1:0] rf_op1,
  input  logic [DW-1:0] rf_op2,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state, state_d;
  logic grant, pick_b;
  logic last_b, gnt_b, wr_q;
  logic sel_wr;
  logic [AW-1:0] sel_waddr, sel_r1, sel_r2;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] hold1_a, hold2_a, hold1_b, hold2_b;
  logic rd_done_a, rd_done_b;

  // Fields of whichever requester wins this cycle's arbitration
  assign sel_wr    = pick_b ? wr_b     : wr_a;
  assign sel_waddr = pick_b ? waddr_b  : waddr_a;
  assign sel_wdata = pick_b ? wdata_b  : wdata_a;
  assign sel_r1    = pick_b ? raddr1_b : raddr1_a;
  assign sel_r2    = pick_b ? raddr2_b : raddr2_a;

  // Regfile read data lands in the DONE cycle, so it bypasses the hold register then
  assign rd_done_a = ack_a & ~wr_q;
  assign rd_done_b = ack_b & ~wr_q;
  assign rdata1_a  = rd_done_a ? rf_op1 : hold1_a;
  assign rdata2_a  = rd_done_a ? rf_op2 : hold2_a;
  assign rdata1_b  = rd_done_b ? rf_op1 : hold1_b;
  assign rdata2_b  = rd_done_b ? rf_op2 : hold2_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and arbitration; B wins only if A is idle or A was granted last
  always_comb begin
    state_d = state;
    grant   = 1'b0;
    pick_b  = req_b & (~req_a | ~last_b);
    case (state)
      IDLE: begin
        if (req_a | req_b) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = DONE;
      DONE: begin
        if (req_a | req_b) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered strobes, latched fields, acks and read-data hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_en   <= 1'b0;
      rf_rd   <= 1'b0;
      rf_wt   <= 1'b0;
      rf_si   <= '0;
      rf_so1  <= '0;
      rf_so2  <= '0;
      rf_ip   <= '0;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      busy    <= 1'b0;
      last_b  <= 1'b1;
      gnt_b   <= 1'b0;
      wr_q    <= 1'b0;
      hold1_a <= '0;
      hold2_a <= '0;
      hold1_b <= '0;
      hold2_b <= '0;
    end else begin
      rf_en <= grant;
      rf_wt <= grant & sel_wr;
      rf_rd <= grant & ~sel_wr;
      ack_a <= (state == ISSUE) & ~gnt_b;
      ack_b <= (state == ISSUE) & gnt_b;
      busy  <= (state_d != IDLE);
      if (grant) begin
        gnt_b  <= pick_b;
        last_b <= pick_b;
        wr_q   <= sel_wr;
        rf_si  <= sel_waddr;
        rf_so1 <= sel_r1;
        rf_so2 <= sel_r2;
        rf_ip  <= sel_wdata;
      end
      if (rd_done_a) begin
        hold1_a <= rf_op1;
        hold2_a <= rf_op2;
      end
      if (rd_done_b) begin
        hold1_b <= rf_op1;
        hold2_b <= rf_op2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: behavioural regfile, transaction-level reference model,
// directed scenarios plus randomized two-requester traffic.
module tb_regfile_port_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 16;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0, wr_a = 1'b0, req_b = 1'b0, wr_b = 1'b0;
  logic [AW-1:0] waddr_a = '0, raddr1_a = '0, raddr2_a = '0;
  logic [AW-1:0] waddr_b = '0, raddr1_b = '0, raddr2_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic ack_a, ack_b, rf_en, rf_rd, rf_wt, busy;
  logic [DW-1:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b, rf_ip;
  logic [AW-1:0] rf_si, rf_so1, rf_so2;
  logic [DW-1:0] rf_op1 = '0, rf_op2 = '0;

  always #5 clk = ~clk;

  regfile_port_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .wr_a(wr_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .raddr1_a(raddr1_a), .raddr2_a(raddr2_a), .ack_a(ack_a),
    .rdata1_a(rdata1_a), .rdata2_a(rdata2_a),
    .req_b(req_b), .wr_b(wr_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr1_b(raddr1_b), .raddr2_b(raddr2_b), .ack_b(ack_b),
    .rdata1_b(rdata1_b), .rdata2_b(rdata2_b),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_wt(rf_wt),
    .rf_si(rf_si), .rf_so1(rf_so1), .rf_so2(rf_so2), .rf_ip(rf_ip),
    .rf_op1(rf_op1), .rf_op2(rf_op2), .busy(busy)
  );

  // Behavioural regfile following the registered-read contract
  logic [DW-1:0] rf_mem [NR];
  always @(posedge clk) begin
    if (rf_en && rf_wt) rf_mem[rf_si] <= rf_ip;
    if (rf_en && rf_rd) begin
      rf_op1 <= rf_mem[rf_so1];
      rf_op2 <= rf_mem[rf_so2];
    end
  end

  int total = 0;
  int bad = 0;

  // Reference model state: register contents, arbitration history, in-flight transaction
  logic [DW-1:0] ref_mem [NR];
  txn_t qa[$], qb[$];
  int cyc = 0, busy_until = -1, g_edge = -10;
  bit m_last_b = 1'b1, ex_who = 1'b0;
  txn_t ex;
  logic [DW-1:0] ex_r1 = '0, ex_r2 = '0;
  logic [DW-1:0] m_rd1_a = '0, m_rd2_a = '0, m_rd1_b = '0, m_rd2_b = '0;
  int ack_log[$], ack_cyc[$];

  function automatic txn_t rnd_txn();
    txn_t t;
    t.wr    = 1'($urandom_range(1, 0));
    t.waddr = AW'($urandom);
    t.wdata = DW'($urandom);
    t.r1    = AW'($urandom);
    t.r2    = AW'($urandom);
    return t;
  endfunction

  function automatic txn_t mk(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    txn_t t;
    t.wr = w; t.waddr = wa; t.wdata = wd; t.r1 = a1; t.r2 = a2;
    return t;
  endfunction

  function automatic txn_t bus_txn(input bit who);
    txn_t t;
    if (who) t = {wr_b, waddr_b, wdata_b, raddr1_b, raddr2_b};
    else     t = {wr_a, waddr_a, wdata_a, raddr1_a, raddr2_a};
    return t;
  endfunction

  task automatic drive(input bit who, input txn_t t);
    if (who) begin
      wr_b = t.wr; waddr_b = t.waddr; wdata_b = t.wdata; raddr1_b = t.r1; raddr2_b = t.r2;
    end else begin
      wr_a = t.wr; waddr_a = t.waddr; wdata_a = t.wdata; raddr1_a = t.r1; raddr2_a = t.r2;
    end
  endtask

  task automatic model_reset();
    busy_until = -1; g_edge = -10; m_last_b = 1'b1;
    m_rd1_a = '0; m_rd2_a = '0; m_rd1_b = '0; m_rd2_b = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) begin @(posedge clk); cyc++; end
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Plays the queued transactions of both requesters and checks every cycle against the model
  task automatic run_traffic(input bit rnd, input string tag);
    int steps, n;
    bit issue, ackc;
    steps = 0;
    forever begin
      if (!req_a && qa.size() > 0 && (!rnd || $urandom_range(1, 0) == 1)) begin
        drive(1'b0, qa.pop_front()); req_a = 1'b1;
      end
      if (!req_b && qb.size() > 0 && (!rnd || $urandom_range(1, 0) == 1)) begin
        drive(1'b1, qb.pop_front()); req_b = 1'b1;
      end
      if (qa.size() == 0 && qb.size() == 0 && !req_a && !req_b && cyc > busy_until) break;
      if (steps > 1000) begin
        total++; bad++;
        $display("FAIL %s timeout: still busy after %0d cycles, want completion", tag, steps);
        req_a = 1'b0; req_b = 1'b0; qa.delete(); qb.delete();
        break;
      end
      n = cyc + 1;
      if (n > busy_until && (req_a || req_b)) begin
        ex_who = req_b && (!req_a || !m_last_b);
        m_last_b = ex_who;
        ex = bus_txn(ex_who);
        g_edge = n;
        busy_until = n + 1;
        if (ex.wr) ref_mem[ex.waddr] = ex.wdata;
        else begin ex_r1 = ref_mem[ex.r1]; ex_r2 = ref_mem[ex.r2]; end
      end
      @(posedge clk); cyc = n; steps++; #1;
      issue = (cyc == g_edge);
      ackc  = (cyc == g_edge + 1);
      total++;
      if ({rf_en, rf_wt, rf_rd} !== {issue, issue && ex.wr, issue && !ex.wr}) begin
        bad++;
        $display("FAIL %s strobes cyc=%0d: en/wt/rd=%b%b%b want %b%b%b", tag, cyc,
                 rf_en, rf_wt, rf_rd, issue, issue && ex.wr, issue && !ex.wr);
      end
      total++;
      if ({ack_a, ack_b, busy} !== {ackc && !ex_who, ackc && ex_who, cyc <= busy_until}) begin
        bad++;
        $display("FAIL %s ack/busy cyc=%0d: ack_a/ack_b/busy=%b%b%b want %b%b%b", tag, cyc,
                 ack_a, ack_b, busy, ackc && !ex_who, ackc && ex_who, cyc <= busy_until);
      end
      if (issue) begin
        total++;
        if ({rf_si, rf_so1, rf_so2, rf_ip} !== {ex.waddr, ex.r1, ex.r2, ex.wdata}) begin
          bad++;
          $display("FAIL %s issue fields: si/so1/so2/ip=%h/%h/%h/%h want %h/%h/%h/%h", tag,
                   rf_si, rf_so1, rf_so2, rf_ip, ex.waddr, ex.r1, ex.r2, ex.wdata);
        end
        drive(ex_who, rnd_txn());
      end
      if (ackc) begin
        ack_log.push_back(int'(ex_who));
        ack_cyc.push_back(cyc);
        if (!ex.wr) begin
          if (ex_who) begin m_rd1_b = ex_r1; m_rd2_b = ex_r2; end
          else begin m_rd1_a = ex_r1; m_rd2_a = ex_r2; end
        end
        if (ex_who) req_b = 1'b0; else req_a = 1'b0;
      end
      total++;
      if ({rdata1_a, rdata2_a, rdata1_b, rdata2_b} !== {m_rd1_a, m_rd2_a, m_rd1_b, m_rd2_b}) begin
        bad++;
        $display("FAIL %s rdata cyc=%0d: %h %h %h %h want %h %h %h %h", tag, cyc,
                 rdata1_a, rdata2_a, rdata1_b, rdata2_b, m_rd1_a, m_rd2_a, m_rd1_b, m_rd2_b);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({ack_a, ack_b, busy, rf_en, rf_rd, rf_wt, rf_si, rf_so1, rf_so2, rf_ip,
         rdata1_a, rdata2_a, rdata1_b, rdata2_b} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: some output nonzero, busy=%b en=%b ip=%h rd1a=%h", busy, rf_en,
               rf_ip, rdata1_a);
    end
    repeat (3) begin
      @(posedge clk); cyc++; #1;
      total++;
      if ({ack_a, ack_b, busy, rf_en} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle: ack_a/ack_b/busy/en=%b%b%b%b want 0000", ack_a, ack_b, busy, rf_en);
      end
    end
  endtask

  task automatic test_write();
    qa.push_back(mk(1'b1, AW'(0), 32'h11111111, AW'(5), AW'(6)));
    qa.push_back(mk(1'b1, AW'(1), 32'h22222222, AW'(7), AW'(8)));
    run_traffic(1'b0, "write");
    total++;
    if ({rf_si, rf_ip} !== {AW'(1), 32'h22222222}) begin
      bad++;
      $display("FAIL write_hold: si/ip=%h/%h want 1/22222222", rf_si, rf_ip);
    end
  endtask

  task automatic test_read();
    qa.push_back(mk(1'b0, AW'(9), 32'h0, AW'(0), AW'(1)));
    run_traffic(1'b0, "read");
    total++;
    if ({rdata1_a, rdata2_a} !== {32'h11111111, 32'h22222222}) begin
      bad++;
      $display("FAIL read_r0_r1: rdata1/2_a=%h/%h want 11111111/22222222", rdata1_a, rdata2_a);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    ack_log.delete(); ack_cyc.delete();
    qa.push_back(mk(1'b1, AW'(4), DW'($urandom), AW'(0), AW'(0)));
    qa.push_back(mk(1'b1, AW'(5), DW'($urandom), AW'(0), AW'(0)));
    qb.push_back(mk(1'b1, AW'(8), DW'($urandom), AW'(0), AW'(0)));
    qb.push_back(mk(1'b1, AW'(9), DW'($urandom), AW'(0), AW'(0)));
    run_traffic(1'b0, "rr");
    total++;
    if (ack_log.size() != 4 || ack_log[0] != 0 || ack_log[1] != 1 || ack_log[2] != 0 || ack_log[3] != 1) begin
      bad++;
      $display("FAIL rr_order: %0d acks, order %p want A,B,A,B", ack_log.size(), ack_log);
    end
    for (int i = 1; i < ack_cyc.size(); i++) begin
      total++;
      if (ack_cyc[i] - ack_cyc[i-1] != 2) begin
        bad++;
        $display("FAIL rr_spacing: ack gap %0d want 2", ack_cyc[i] - ack_cyc[i-1]);
      end
    end
  endtask

  task automatic test_b_then_a();
    qb.push_back(mk(1'b1, AW'(3), 32'hDEADBEEF, AW'(2), AW'(2)));
    run_traffic(1'b0, "b_write");
    qa.push_back(mk(1'b0, AW'(0), 32'h0, AW'(3), AW'(4)));
    run_traffic(1'b0, "a_read");
    total++;
    if (rdata1_a !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL b_then_a: rdata1_a=%h want deadbeef", rdata1_a);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, mk(1'b0, AW'(0), 32'h0, AW'(3), AW'(1)));
    req_a = 1'b1;
    @(posedge clk); cyc++; #1;
    total++;
    if ({rf_en, rf_rd, rf_so1} !== {1'b1, 1'b1, AW'(3)}) begin
      bad++;
      $display("FAIL mid_issue: en/rd/so1=%b/%b/%h want 1/1/3", rf_en, rf_rd, rf_so1);
    end
    rst = 1'b1;
    #1;
    req_a = 1'b0;
    total++;
    if ({ack_a, busy, rf_en, rf_rd, rf_so1, rdata1_a, rdata2_a} !== '0) begin
      bad++;
      $display("FAIL mid_reset: ack/busy/en=%b%b%b rdata1/2_a=%h/%h want all 0", ack_a, busy,
               rf_en, rdata1_a, rdata2_a);
    end
    @(posedge clk); cyc++; #1;
    total++;
    if ({ack_a, ack_b, busy} !== 3'b000) begin
      bad++;
      $display("FAIL mid_noack: ack_a/ack_b/busy=%b%b%b want 000", ack_a, ack_b, busy);
    end
    rst = 1'b0;
    model_reset();
    qa.push_back(mk(1'b0, AW'(0), 32'h0, AW'(3), AW'(1)));
    run_traffic(1'b0, "post_reset");
    total++;
    if ({rdata1_a, rdata2_a} !== {32'hDEADBEEF, 32'h22222222}) begin
      bad++;
      $display("FAIL post_reset_read: rdata1/2_a=%h/%h want deadbeef/22222222", rdata1_a, rdata2_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      qa.push_back(rnd_txn());
      qb.push_back(rnd_txn());
    end
    run_traffic(1'b1, "random");
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      rf_mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_b_then_a();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
